// File: rtl/xcorr_stream.sv
// xcorr_stream: frame-based streaming cross-correlator.
//
// Accepts one pair of N-sample windows per in_valid/in_ready handshake and
// evaluates all 2N-1 lags, one lag per cycle, adding each lag sum into its
// own accumulator. After INT_FRAMES frames have been integrated, the
// accumulators are streamed out in lag order 0..2N-2 on a valid/ready
// interface and then cleared for the next integration.
//
// Lag k has offset d = k-(N-1):
//   acc[k] += sum_{y=0..N-1-|d|} in1[y+max(0,d)] * in2[y+max(0,-d)]
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   input frame valid
//   in_ready   block can accept a frame (only in IDLE)
//   in1, in2   sample windows, sample j at bits [j*DW +: DW], unsigned
//   out_valid  lag result valid
//   out_ready  sink accepts the result
//   out_data   accumulated correlation for lag out_lag
//   out_lag    lag index 0..2N-2
//   out_last   high together with lag 2N-2
//   ovf        sticky overflow flag
//
// Build option:
//   XCORR_SAT_EN  defined: accumulator updates saturate at 2^OUT_W-1 and any
//                 saturating update sets ovf until rst.
//                 undefined: accumulators wrap modulo 2^OUT_W, ovf is 0.

module xcorr_stream #(
    parameter int unsigned N          = 3,
    parameter int unsigned DW         = 1,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned INT_FRAMES = 1,
    localparam int unsigned LAG_W     = $clog2(2 * N - 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DW-1:0]     in1,
    input  logic [N*DW-1:0]     in2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic [LAG_W-1:0]    out_lag,
    output logic                out_last,
    output logic                ovf
);

    localparam int unsigned NUM_LAGS = 2 * N - 1;
    // Full-precision lag sum: up to N products of 2*DW bits each.
    localparam int unsigned SUM_W    = 2 * DW + $clog2(N + 1);
    // One spare bit so the accumulator update never loses its carry.
    localparam int unsigned ADD_W    = ((OUT_W > SUM_W) ? OUT_W : SUM_W) + 1;
    localparam int unsigned FRM_W    = (INT_FRAMES > 1) ? $clog2(INT_FRAMES) : 1;
    localparam int unsigned IDX_W    = $clog2(N);

    localparam logic [LAG_W-1:0] LAST_LAG = LAG_W'(NUM_LAGS - 1);
    localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(INT_FRAMES - 1);
    localparam logic [OUT_W-1:0] MAX_ACC  = '1;

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StDump
    } state_e;

    state_e            state_q, state_d;
    logic [LAG_W-1:0]  lag_q, lag_d;
    logic [FRM_W-1:0]  frame_q, frame_d;
    logic [N*DW-1:0]   win_a_q, win_a_d;
    logic [N*DW-1:0]   win_b_q, win_b_d;
    logic [OUT_W-1:0]  acc_q [NUM_LAGS];
    logic [OUT_W-1:0]  acc_d [NUM_LAGS];

    // Unpacked views of the registered windows.
    logic [DW-1:0]     a_s [N];
    logic [DW-1:0]     b_s [N];

    logic [SUM_W-1:0]  lag_sum [NUM_LAGS];
    logic [2*DW-1:0]   prod;
    logic [SUM_W-1:0]  cur_sum;
    logic [ADD_W-1:0]  sum_ext;
    logic [OUT_W-1:0]  acc_new;

`ifdef XCORR_SAT_EN
    logic              ovf_q, ovf_d;
    logic              sat_hit;
`endif

    always_comb begin
        for (int unsigned j = 0; j < N; j++) begin
            a_s[j] = win_a_q[j*DW +: DW];
            b_s[j] = win_b_q[j*DW +: DW];
        end
    end

    // All lag sums from the registered windows; the current lag picks one.
    always_comb begin
        int unsigned ia;
        int unsigned ib;
        prod = '0;
        ia   = 0;
        ib   = 0;
        for (int unsigned k = 0; k < NUM_LAGS; k++) begin
            lag_sum[k] = '0;
            for (int unsigned y = 0; y < N; y++) begin
                // Positive offsets shift window A, negative offsets shift window B.
                ia = (k >= N - 1) ? (y + k - (N - 1)) : y;
                ib = (k >= N - 1) ? y : (y + (N - 1) - k);
                if (ia < N && ib < N) begin
                    prod       = (2*DW)'(a_s[IDX_W'(ia)]) * (2*DW)'(b_s[IDX_W'(ib)]);
                    lag_sum[k] = lag_sum[k] + SUM_W'(prod);
                end
            end
        end
    end

    always_comb begin
        cur_sum = lag_sum[lag_q];
        sum_ext = ADD_W'(acc_q[lag_q]) + ADD_W'(cur_sum);
`ifdef XCORR_SAT_EN
        sat_hit = (sum_ext > ADD_W'(MAX_ACC));
        acc_new = sat_hit ? MAX_ACC : sum_ext[OUT_W-1:0];
`else
        acc_new = sum_ext[OUT_W-1:0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        lag_d     = lag_q;
        frame_d   = frame_q;
        win_a_d   = win_a_q;
        win_b_d   = win_b_q;
        acc_d     = acc_q;
`ifdef XCORR_SAT_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    win_a_d = in1;
                    win_b_d = in2;
                    lag_d   = '0;
                    state_d = StCompute;
                end
            end

            StCompute: begin
                acc_d[lag_q] = acc_new;
`ifdef XCORR_SAT_EN
                ovf_d = ovf_q | sat_hit;
`endif
                if (lag_q == LAST_LAG) begin
                    lag_d = '0;
                    if (frame_q == LAST_FRM) begin
                        state_d = StDump;
                    end else begin
                        frame_d = frame_q + 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    lag_d = lag_q + 1'b1;
                end
            end

            StDump: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (lag_q == LAST_LAG) begin
                        for (int unsigned k = 0; k < NUM_LAGS; k++) begin
                            acc_d[k] = '0;
                        end
                        frame_d = '0;
                        lag_d   = '0;
                        state_d = StIdle;
                    end else begin
                        lag_d = lag_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            lag_q   <= '0;
            frame_q <= '0;
            win_a_q <= '0;
            win_b_q <= '0;
            for (int unsigned k = 0; k < NUM_LAGS; k++) begin
                acc_q[k] <= '0;
            end
`ifdef XCORR_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lag_q   <= lag_d;
            frame_q <= frame_d;
            win_a_q <= win_a_d;
            win_b_q <= win_b_d;
            for (int unsigned k = 0; k < NUM_LAGS; k++) begin
                acc_q[k] <= acc_d[k];
            end
`ifdef XCORR_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Data/lag come straight from registers, so they hold under backpressure.
    assign out_data = acc_q[lag_q];
    assign out_lag  = lag_q;
    assign out_last = (state_q == StDump) && (lag_q == LAST_LAG);

`ifdef XCORR_SAT_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_xcorr_stream.sv
// Bench for xcorr_stream. Three instances share clock and reset:
//   dut0: N=3, DW=1, OUT_W=8, INT_FRAMES=1  (table vectors, random frames,
//         latency, backpressure, reset mid-compute)
//   dut1: N=3, DW=1, OUT_W=8, INT_FRAMES=4  (integration and clearing)
//   dut2: N=3, DW=1, OUT_W=3, INT_FRAMES=4  (wrap / saturation, ovf)
// Expected lag results are queued when a frame is driven and compared when
// the instance hands a result over.

module tb_xcorr_stream;

    localparam int N = 3;

`ifdef XCORR_SAT_EN
    localparam int SAT = 1;
`else
    localparam int SAT = 0;
`endif

    typedef struct {
        int data;
        int lag;
        int last;
    } exp_t;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        int         exp [5];
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic [2:0] in1       [3];
    logic [2:0] in2       [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [2:0] out_lag   [3];
    logic       out_last  [3];
    logic       ovf       [3];
    logic [7:0] od0;
    logic [7:0] od1;
    logic [2:0] od2;

    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    xcorr_stream #(.N(3), .DW(1), .OUT_W(8), .INT_FRAMES(1)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in1(in1[0]), .in2(in2[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(od0), .out_lag(out_lag[0]), .out_last(out_last[0]), .ovf(ovf[0])
    );

    xcorr_stream #(.N(3), .DW(1), .OUT_W(8), .INT_FRAMES(4)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in1(in1[1]), .in2(in2[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(od1), .out_lag(out_lag[1]), .out_last(out_last[1]), .ovf(ovf[1])
    );

    xcorr_stream #(.N(3), .DW(1), .OUT_W(3), .INT_FRAMES(4)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in1(in1[2]), .in2(in2[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(od2), .out_lag(out_lag[2]), .out_last(out_last[2]), .ovf(ovf[2])
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int get_data(input int i);
        case (i)
            0:       return int'(od0);
            1:       return int'(od1);
            default: return int'(od2);
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    // Reference lag sum straight from the pair-wise definition: in1[i]*in2[j]
    // contributes to lag k when i-j equals k-(N-1).
    function automatic int model_lag(input logic [2:0] a, input logic [2:0] b, input int k);
        int s = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (i - j == k - (N - 1)) s += int'(a[i]) * int'(b[j]);
            end
        end
        return s;
    endfunction

    task automatic push_exp(input int i, input int d [5]);
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            e.data = d[k];
            e.lag  = k;
            e.last = (k == 4) ? 1 : 0;
            case (i)
                0:       sb0.push_back(e);
                1:       sb1.push_back(e);
                default: sb2.push_back(e);
            endcase
        end
    endtask

    task automatic pop_cmp(input int i);
        exp_t e;
        check($sformatf("dut%0d_result_expected", i), int'(qsize(i) != 0), 1);
        if (qsize(i) != 0) begin
            case (i)
                0:       e = sb0.pop_front();
                1:       e = sb1.pop_front();
                default: e = sb2.pop_front();
            endcase
            check($sformatf("dut%0d_lag%0d_data", i, e.lag), get_data(i), e.data);
            check($sformatf("dut%0d_lag%0d_lag", i, e.lag), int'(out_lag[i]), e.lag);
            check($sformatf("dut%0d_lag%0d_last", i, e.lag), int'(out_last[i]), e.last);
        end
    endtask

    // Scoreboard monitor: a result is transferred when valid and ready are
    // both high; sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (out_valid[i] && out_ready[i]) pop_cmp(i);
            end
        end
    end

    task automatic send(input int i, input logic [2:0] a, input logic [2:0] b);
        int c = 0;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b1;
        in1[i]      = a;
        in2[i]      = b;
        @(negedge clk);
        while (!in_ready[i] && c < 200) begin
            @(negedge clk);
            c++;
        end
        check($sformatf("dut%0d_accept_ready", i), int'(in_ready[i]), 1);
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i, input bit rnd);
        int c = 0;
        while (qsize(i) != 0 && c < 300) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready[i] = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            c++;
        end
        @(posedge clk);
        #1;
        out_ready[i] = 1'b1;
        check($sformatf("dut%0d_drained", i), qsize(i), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [4];
        int          d    [5];
        logic [2:0]  ra;
        logic [2:0]  rb;

        vecs[0].a = 3'b111; vecs[0].b = 3'b111; vecs[0].exp = '{1, 2, 3, 2, 1};
        vecs[1].a = 3'b001; vecs[1].b = 3'b100; vecs[1].exp = '{1, 0, 0, 0, 0};
        vecs[2].a = 3'b100; vecs[2].b = 3'b001; vecs[2].exp = '{0, 0, 0, 0, 1};
        vecs[3].a = 3'b101; vecs[3].b = 3'b011; vecs[3].exp = '{0, 1, 1, 1, 1};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in1[i]       = '0;
            in2[i]       = '0;
            out_ready[i] = 1'b1;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_in_ready%0d", i), int'(in_ready[i]), 1);
            check($sformatf("rst_out_valid%0d", i), int'(out_valid[i]), 0);
            check($sformatf("rst_out_data%0d", i), get_data(i), 0);
            check($sformatf("rst_out_lag%0d", i), int'(out_lag[i]), 0);
            check($sformatf("rst_out_last%0d", i), int'(out_last[i]), 0);
            check($sformatf("rst_ovf%0d", i), int'(ovf[i]), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table vectors; the first also checks the first out_valid timing.
        for (int v = 0; v < 4; v++) begin
            push_exp(0, vecs[v].exp);
            send(0, vecs[v].a, vecs[v].b);
            if (v == 0) begin
                for (int n = 0; n <= 5; n++) begin
                    @(negedge clk);
                    check($sformatf("latency_valid_after_T+%0d", n), int'(out_valid[0]),
                          (n == 5) ? 1 : 0);
                end
            end
            drain(0, 1'b0);
        end

        // Random frames against the reference model, random sink stalls.
        for (int r = 0; r < 8; r++) begin
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            for (int k = 0; k < 5; k++) d[k] = model_lag(ra, rb, k);
            push_exp(0, d);
            send(0, ra, rb);
            drain(0, 1'b1);
        end

        // Backpressure on lag 2, with a frame offered during DUMP.
        d = '{1, 2, 3, 2, 1};
        push_exp(0, d);
        send(0, 3'b111, 3'b111);
        for (int c = 0; c < 50 && !out_valid[0]; c++) @(negedge clk);
        check("bp_first_valid", int'(out_valid[0]), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in1[0]       = 3'b010;
        in2[0]       = 3'b010;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_valid", int'(out_valid[0]), 1);
            check("bp_hold_data", get_data(0), 3);
            check("bp_hold_lag", int'(out_lag[0]), 2);
            check("bp_hold_last", int'(out_last[0]), 0);
            check("bp_in_ready_low", int'(in_ready[0]), 0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b0;
        drain(0, 1'b0);
        repeat (12) @(negedge clk);
        check("bp_no_extra_valid", int'(out_valid[0]), 0);

        // Integration over four frames, then a second integration from zero.
        for (int f = 0; f < 3; f++) send(1, 3'b111, 3'b111);
        repeat (12) @(negedge clk);
        check("int_no_early_valid", int'(out_valid[1]), 0);
        check("int_ready_between_frames", int'(in_ready[1]), 1);
        d = '{4, 8, 12, 8, 4};
        push_exp(1, d);
        send(1, 3'b111, 3'b111);
        drain(1, 1'b0);
        d = '{4, 0, 0, 0, 0};
        push_exp(1, d);
        for (int f = 0; f < 4; f++) send(1, 3'b001, 3'b100);
        drain(1, 1'b0);

        // Narrow accumulators: wrap or saturate depending on the build.
        for (int f = 0; f < 2; f++) send(2, 3'b111, 3'b111);
        repeat (8) @(negedge clk);
        check("ovf_clear_before_limit", int'(ovf[2]), 0);
        if (SAT != 0) d = '{4, 7, 7, 7, 4};
        else          d = '{4, 0, 4, 0, 4};
        push_exp(2, d);
        for (int f = 0; f < 2; f++) send(2, 3'b111, 3'b111);
        drain(2, 1'b0);
        check("ovf_after_integration", int'(ovf[2]), SAT);
        repeat (4) @(negedge clk);
        check("ovf_sticky", int'(ovf[2]), SAT);

        // Reset on the second compute cycle discards the frame.
        send(0, 3'b111, 3'b111);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_in_ready", int'(in_ready[0]), 1);
        check("rst_mid_out_valid", int'(out_valid[0]), 0);
        check("rst_mid_ovf_cleared", int'(ovf[2]), 0);
        repeat (12) @(negedge clk);
        check("rst_mid_no_valid", int'(out_valid[0]), 0);
        d = '{1, 2, 3, 2, 1};
        push_exp(0, d);
        send(0, 3'b111, 3'b111);
        drain(0, 1'b0);

        repeat (10) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("final_queue%0d_empty", i), qsize(i), 0);
            check($sformatf("final_out_valid%0d", i), int'(out_valid[i]), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
